// File: rtl/params_pkg.sv
// Reduction parameters shared by the Barrett datapath and the scheduler in front of it.
// Modulus, bitlength and mu are fixed here; mu is derived so it always tracks the modulus.
package params_pkg;
  localparam int MODULUS_LENGTH  = 23;
  localparam int DATA_LENGTH     = 2 * MODULUS_LENGTH;
  localparam int QBL_W           = 6;
  localparam int BARRETT_LATENCY = 3;
  localparam int NUM_REQ_DEFAULT = 4;

  localparam logic [MODULUS_LENGTH-1:0] MODULUS    = 23'd8380417;
  localparam logic [QBL_W-1:0]          MODULUS_BL = QBL_W'(MODULUS_LENGTH);
  // mu = floor(2^(2k) / q) with k the modulus bitlength
  localparam logic [MODULUS_LENGTH:0]   MU =
    (MODULUS_LENGTH + 1)'((64'd1 << (2 * MODULUS_LENGTH)) / 64'(MODULUS));

  typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/barrett_pipelined.sv
// Three-stage Barrett reducer: result = x mod q for x < 2^(2k), valid_o follows start_i by
// BARRETT_LATENCY cycles. Reset is synchronous on rst_ni.
module barrett_pipelined
  import params_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [DATA_LENGTH-1:0]    x_i,
  input  logic [MODULUS_LENGTH-1:0] q_i,
  input  logic [QBL_W-1:0]          q_bl_i,
  input  logic [MODULUS_LENGTH:0]   mu_i,
  output logic [DATA_LENGTH-1:0]    result_o,
  output logic                      valid_o
);
  localparam int WW = 2 * DATA_LENGTH;

  logic [WW-1:0]          prod;
  logic [DATA_LENGTH-1:0] x_s1;
  logic [DATA_LENGTH-1:0] r_s2;
  logic [DATA_LENGTH-1:0] q_ext;
  logic                   vld_s1;
  logic                   vld_s2;

  assign q_ext = DATA_LENGTH'(q_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prod     <= '0;
      x_s1     <= '0;
      r_s2     <= '0;
      result_o <= '0;
      vld_s1   <= 1'b0;
      vld_s2   <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      vld_s1  <= start_i;
      vld_s2  <= vld_s1;
      valid_o <= vld_s2;
      prod    <= WW'(x_i >> (q_bl_i - QBL_W'(1))) * WW'(mu_i);
      x_s1    <= x_i;
      // quotient estimate is at most two short, so the remainder is below 3q
      r_s2    <= DATA_LENGTH'(WW'(x_s1) - (prod >> (q_bl_i + QBL_W'(1))) * WW'(q_i));
      if (r_s2 >= (q_ext << 1)) begin
        result_o <= r_s2 - (q_ext << 1);
      end else if (r_s2 >= q_ext) begin
        result_o <= r_s2 - q_ext;
      end else begin
        result_o <= r_s2;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, cyclically.
// The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic           en,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);
  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    if (en) begin
      // walk from farthest to nearest so the nearest request is the last one written
      for (int i = N - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % N;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_idx  = IDW'(idx);
        end
      end
    end
  end
endmodule

// File: rtl/barrett_sched.sv
// Round-robin scheduler sharing one barrett_pipelined reducer among NUM_REQ requesters.
// Defining BARRETT_SCHED_STATS_EN adds per-requester handshake counters on stat_cnt_o.
module barrett_sched
  import params_pkg::DATA_LENGTH, params_pkg::MODULUS, params_pkg::MODULUS_BL,
         params_pkg::MU, params_pkg::NUM_REQ_DEFAULT;
#(
  parameter  int NUM_REQ         = NUM_REQ_DEFAULT,
  parameter  int BARRETT_LATENCY = params_pkg::BARRETT_LATENCY,
  localparam int IDW             = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_LENGTH-1:0] req_x_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [DATA_LENGTH-1:0]              rsp_data_o,
  output logic [IDW-1:0]                      rsp_id_o,
  output logic                                busy_o,
  output logic                                err_o
`ifdef BARRETT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]            stat_cnt_o
`endif
);
  localparam int CW = $clog2(BARRETT_LATENCY + 3);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } sched_tag_t;

  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         gnt_idx;
  logic                   hs;
  logic                   iss_vld;
  logic [IDW-1:0]         iss_id;
  logic [DATA_LENGTH-1:0] iss_x;
  sched_tag_t             tag_pipe [BARRETT_LATENCY];
  sched_tag_t             tag_out;
  logic                   red_valid;
  logic [DATA_LENGTH-1:0] red_result;
  logic [CW-1:0]          cnt;

  // Handshake: a requester's operand is taken on a rising edge where its valid and ready are both high.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid_i),
    .en      (en_i & ~rst_i),
    .ptr     (rr_ptr),
    .gnt     (req_ready_o),
    .gnt_idx (gnt_idx)
  );

  assign hs      = |(req_valid_i & req_ready_o);
  assign tag_out = tag_pipe[BARRETT_LATENCY-1];
  assign busy_o  = (cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      iss_vld <= 1'b0;
      iss_id  <= '0;
      iss_x   <= '0;
    end else begin
      iss_vld <= hs;
      if (hs) begin
        iss_id <= gnt_idx;
        iss_x  <= req_x_i[gnt_idx];
        rr_ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

  barrett_pipelined u_red (
    .clk_i    (clk_i),
    .rst_ni   (~rst_i),
    .start_i  (iss_vld),
    .x_i      (iss_x),
    .q_i      (MODULUS),
    .q_bl_i   (MODULUS_BL),
    .mu_i     (MU),
    .result_o (red_result),
    .valid_o  (red_valid)
  );

  // Tag shadow of the reducer pipeline; its vld must line up with valid_o every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BARRETT_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{vld: iss_vld, id: iss_id};
      for (int i = 1; i < BARRETT_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
      err_o       <= 1'b0;
      cnt         <= '0;
    end else begin
      rsp_valid_o <= '0;
      if (red_valid) begin
        rsp_data_o  <= red_result;
        rsp_id_o    <= tag_out.id;
        rsp_valid_o <= NUM_REQ'(1) << tag_out.id;
      end
      if (tag_out.vld != red_valid) err_o <= 1'b1;
      cnt <= cnt + CW'(hs) - CW'(|rsp_valid_o);
    end
  end

`ifdef BARRETT_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) stat_cnt_o[i] <= stat_cnt_o[i] + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_barrett_sched.sv
// Scoreboard bench for barrett_sched: directed vectors plus a randomised back-to-back run.
// Expected results are pushed at each handshake and popped by an independent response monitor.
module tb_barrett_sched;
  import params_pkg::*;

  localparam int     N   = 4;
  localparam int     IDW = 2;
  localparam int     L   = BARRETT_LATENCY;
  localparam int     DL  = DATA_LENGTH;
  localparam int     EW  = 32 + IDW + DL;
  localparam longint Q   = 64'd8380417;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  logic [N-1:0]         req_valid;
  logic [N-1:0][DL-1:0] req_x;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         rsp_valid;
  logic [DL-1:0]        rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 busy;
  logic                 err;
`ifdef BARRETT_SCHED_STATS_EN
  logic [N-1:0][31:0]   stat_cnt;
`endif

  barrett_sched #(.NUM_REQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .req_valid_i (req_valid),
    .req_x_i     (req_x),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .busy_o      (busy),
    .err_o       (err)
`ifdef BARRETT_SCHED_STATS_EN
    ,
    .stat_cnt_o  (stat_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_hs     = 0;
  logic [N-1:0]  hs_mask = '0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard producer: expected {due cycle, id, x mod q} per handshake
  always @(posedge clk) begin
    hs_mask = req_valid & req_ready;
    if (rst) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hs_mask[i]) begin
          exp_q.push_back({32'(cyc + L + 2), IDW'(i), DL'(64'(req_x[i]) % Q)});
          n_hs++;
        end
      end
    end
    cyc++;
  end

  // response monitor
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data %0d, expected no response", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e[DL-1:0]));
        check("rsp_id", 64'(rsp_id), 64'(e[DL+IDW-1:DL]));
        check("rsp_onehot", 64'(rsp_valid), 64'(1) << e[DL+IDW-1:DL]);
        check("rsp_latency", 64'(cyc), 64'(e[EW-1:EW-32]));
        check("err_clear", 64'(err), 64'(0));
      end
    end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1:EW-32]) < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no response, expected one due at cycle %0d", exp_q[0][EW-1:EW-32]);
      void'(exp_q.pop_front());
    end
    check("cnt_bound", 64'(dut.cnt <= L + 2), 64'(1));
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
    check("drain", 64'(exp_q.size() == 0 && !busy), 64'(1));
  endtask

  logic [DL-1:0] bvec [6];
  int target;

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = '1;
    req_x     = '0;

    // reset state, with every requester asking
    @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;

    // single request from requester 2: 8380418 mod 8380417 = 1
    @(negedge clk);
    req_x[2]  = DL'(8380418);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(req_ready), 64'(4'b0100));
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 20 && rsp_valid == '0; k++) @(negedge clk);
    check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("single_rsp_data", 64'(rsp_data), 64'(1));
    check("single_busy_hold", 64'(busy), 64'(1));
    @(negedge clk);
    check("single_busy_fall", 64'(busy), 64'(0));
    drain();

    // rotation: all four requesters valid for 8 cycles, data = index
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) req_x[i] = DL'(i) + DL'(Q);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rot_grant", 64'(req_ready), 64'(1) << (k % 4));
      @(negedge clk);
    end
    req_valid = '0;
    drain();
`ifdef BARRETT_SCHED_STATS_EN
    for (int i = 0; i < N; i++) check("stat_cnt", 64'(stat_cnt[i]), 64'(2));
`endif

    // enable low for 5 cycles with requesters 1 and 3 waiting; pointer sits at 0
    en        = 1'b0;
    req_x[1]  = DL'(100);
    req_x[3]  = DL'(16760837);
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("en_low_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    en = 1'b1;
    #1;
    check("en_first_grant", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    #1;
    check("en_second_grant", 64'(req_ready), 64'(4'b1000));
    @(negedge clk);
    req_valid = '0;
    drain();

    // three issues, then reset while they are in flight
    req_x[0]  = DL'(12345);
    req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < L + 3; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", 64'(rsp_valid), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_err", 64'(err), 64'(0));
    end

    // boundary operands
    bvec[0] = '0;
    bvec[1] = DL'(Q - 1);
    bvec[2] = DL'(Q);
    bvec[3] = DL'(Q + 1);
    bvec[4] = DL'(2 * Q - 1);
    bvec[5] = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_x[0]  = bvec[k];
      req_valid = 4'b0001;
    end
    @(negedge clk);
    req_valid = '0;
    drain();

    // back-to-back random operands and valid patterns; valid holds until accepted
    target = n_hs + 1000;
    for (int c = 0; c < 5000 && n_hs < target; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (hs_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          req_x[i]     = {14'($urandom_range(0, 16383)), 32'($urandom)};
        end
      end
    end
    req_valid = '0;
    check("rand_issued", 64'(n_hs >= target), 64'(1));
    drain();
    check("final_err", 64'(err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got no completion, expected end before 1000000 ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
